// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, status codes and the
// sequencing FSM state encoding used by the PC/status register block.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  function automatic logic is_halt(input logic [3:0] code);
    return code == I_HALT;
  endfunction

endpackage

// File: rtl/run_counter.sv
// Free-running up-counter with enable and synchronous clear; wraps
// modulo 2^CNT_W with no saturation.
module run_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_state_reg.sv
// Y86 fetch-address and status register with run/halt/fault sequencing
// and retired-instruction / run-cycle counters.
//
// state   | meaning
// IDLE    | pc parked at BOOT_PC, waiting for start
// RUN     | one commit per unstalled cycle
// HALTED  | halt instruction retired; frozen until reset
// FAULT   | address or illegal-instruction fault; frozen until reset
module pc_state_reg
  import y86_pkg::*;
#(
  parameter logic [63:0] BOOT_PC = 64'd0,
  parameter int          CNT_W   = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic [63:0]      new_pc,
  input  logic [3:0]       icode,
  input  logic             imem_error,
  input  logic             instr_valid,
  output logic [63:0]      pc,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_t state, state_next;

  logic commit_normal;
  logic commit_halt;
  logic fault_adr;
  logic fault_ins;
  logic retire_en;
  logic cycle_en;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (fault_adr || fault_ins) state_next = ST_FAULT;
        else if (commit_halt)       state_next = ST_HALTED;
      end
      default: state_next = state;
    endcase
  end

  // Commit decode; fault/halt checks only look at unstalled RUN cycles.
  always_comb begin
    running       = 1'b0;
    cycle_en      = 1'b0;
    commit_normal = 1'b0;
    commit_halt   = 1'b0;
    fault_adr     = 1'b0;
    fault_ins     = 1'b0;
    if (state == ST_RUN) begin
      running  = 1'b1;
      cycle_en = 1'b1;
      if (!stall) begin
        if (imem_error)         fault_adr     = 1'b1;
        else if (!instr_valid)  fault_ins     = 1'b1;
        else if (is_halt(icode)) commit_halt  = 1'b1;
        else                    commit_normal = 1'b1;
      end
    end
  end

  assign retire_en = commit_normal | commit_halt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc   <= BOOT_PC;
      stat <= STAT_AOK;
    end else begin
      if (commit_normal) pc <= new_pc;
      if (fault_adr)        stat <= STAT_ADR;
      else if (fault_ins)   stat <= STAT_INS;
      else if (commit_halt) stat <= STAT_HLT;
    end
  end

  run_counter #(.CNT_W(CNT_W)) u_retired (
    .clock  (clock),
    .clear  (!reset_n),
    .enable (retire_en),
    .count  (retired_cnt)
  );

  run_counter #(.CNT_W(CNT_W)) u_cycles (
    .clock  (clock),
    .clear  (!reset_n),
    .enable (cycle_en),
    .count  (cycle_cnt)
  );

endmodule

// File: tb/tb_pc_state_reg.sv
// Directed bench for pc_state_reg: a 32-bit-counter instance with a
// non-zero boot address, plus a 4-bit-counter instance for wrap checks.
module tb_pc_state_reg;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, stall, imem_error, instr_valid;
  logic [63:0] new_pc;
  logic [3:0]  icode;
  logic [63:0] pc;
  logic [2:0]  stat;
  logic        running;
  logic [31:0] retired_cnt, cycle_cnt;

  logic        w_reset_n, w_start, w_stall, w_imem_error, w_instr_valid;
  logic [63:0] w_new_pc;
  logic [3:0]  w_icode;
  logic [63:0] w_pc;
  logic [2:0]  w_stat;
  logic        w_running;
  logic [3:0]  w_retired_cnt, w_cycle_cnt;

  int total = 0;
  int bad   = 0;

  pc_state_reg #(.BOOT_PC(64'h100), .CNT_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stall(stall),
    .new_pc(new_pc), .icode(icode), .imem_error(imem_error),
    .instr_valid(instr_valid), .pc(pc), .stat(stat), .running(running),
    .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
  );

  pc_state_reg #(.BOOT_PC(64'h0), .CNT_W(4)) dut_w (
    .clock(clock), .reset_n(w_reset_n), .start(w_start), .stall(w_stall),
    .new_pc(w_new_pc), .icode(w_icode), .imem_error(w_imem_error),
    .instr_valid(w_instr_valid), .pc(w_pc), .stat(w_stat), .running(w_running),
    .retired_cnt(w_retired_cnt), .cycle_cnt(w_cycle_cnt)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic [2:0] e_stat,
                         input logic e_run, input logic [31:0] e_ret, input logic [31:0] e_cyc);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_stat"}, 64'(stat), 64'(e_stat));
    chk({tag, "_running"}, 64'(running), 64'(e_run));
    chk({tag, "_retired"}, 64'(retired_cnt), 64'(e_ret));
    chk({tag, "_cycles"}, 64'(cycle_cnt), 64'(e_cyc));
  endtask

  task automatic do_reset_start();
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; imem_error = 1'b0;
    instr_valid = 1'b1; icode = 4'd1; new_pc = 64'h0;
    step(1);
    reset_n = 1'b1; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; imem_error = 1'b0;
    instr_valid = 1'b1; icode = 4'd1; new_pc = 64'h0;
    w_reset_n = 1'b0; w_start = 1'b0; w_stall = 1'b0; w_imem_error = 1'b0;
    w_instr_valid = 1'b1; w_icode = 4'd1; w_new_pc = 64'h0;
    step(2);
    chk_all("reset", 64'h100, 3'd1, 1'b0, 0, 0);

    reset_n = 1'b1; w_reset_n = 1'b1;
    step(2);
    chk_all("idle_wait", 64'h100, 3'd1, 1'b0, 0, 0);

    start = 1'b1;
    step(1);
    start = 1'b0;
    chk_all("start", 64'h100, 3'd1, 1'b1, 0, 0);

    // Three nops
    new_pc = 64'h1; step(1);
    chk("latency_pc", pc, 64'h1);
    new_pc = 64'h2; step(1);
    new_pc = 64'h3; step(1);
    chk_all("nops", 64'h3, 3'd1, 1'b1, 3, 3);

    // Stalls ignore new_pc and also any fault/halt indication
    stall = 1'b1; new_pc = 64'h40;
    step(2);
    imem_error = 1'b1; instr_valid = 1'b0; icode = 4'd0;
    step(1);
    imem_error = 1'b0; instr_valid = 1'b1; icode = 4'd1;
    step(1);
    chk_all("stall", 64'h3, 3'd1, 1'b1, 3, 7);

    stall = 1'b0; new_pc = 64'h20;
    step(1);
    chk_all("commit20", 64'h20, 3'd1, 1'b1, 4, 8);

    icode = 4'd0; new_pc = 64'h0;
    step(1);
    chk_all("halt", 64'h20, 3'd2, 1'b0, 5, 9);

    start = 1'b1; new_pc = 64'h55; icode = 4'd1; imem_error = 1'b1;
    step(3);
    imem_error = 1'b0;
    chk_all("halted_hold", 64'h20, 3'd2, 1'b0, 5, 9);

    // Reset wins over start in the same edge
    reset_n = 1'b0; start = 1'b1;
    step(1);
    chk_all("halt_reset", 64'h100, 3'd1, 1'b0, 0, 0);
    reset_n = 1'b1; start = 1'b0;
    step(1);
    chk("post_reset_idle", 64'(running), 64'd0);

    start = 1'b1; step(1); start = 1'b0;
    imem_error = 1'b1; instr_valid = 1'b0; icode = 4'd0; new_pc = 64'h77;
    step(1);
    imem_error = 1'b0; instr_valid = 1'b1; icode = 4'd1;
    chk_all("adr", 64'h100, 3'd3, 1'b0, 0, 1);
    step(2);
    chk_all("fault_hold", 64'h100, 3'd3, 1'b0, 0, 1);

    do_reset_start();
    instr_valid = 1'b0; icode = 4'd1; new_pc = 64'h66;
    step(1);
    instr_valid = 1'b1;
    chk_all("ins", 64'h100, 3'd4, 1'b0, 0, 1);

    // Reset during RUN with a pending normal commit
    do_reset_start();
    new_pc = 64'h8; step(1);
    chk_all("pre_rst", 64'h8, 3'd1, 1'b1, 1, 1);
    new_pc = 64'h9; reset_n = 1'b0;
    step(1);
    chk_all("run_reset", 64'h100, 3'd1, 1'b0, 0, 0);
    reset_n = 1'b1;

    // 4-bit counters: 17 commits wrap to 1
    w_start = 1'b1; step(1); w_start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      w_new_pc = 64'(i);
      step(1);
    end
    chk("wrap_retired", 64'(w_retired_cnt), 64'd1);
    chk("wrap_cycles", 64'(w_cycle_cnt), 64'd1);
    chk("wrap_pc", w_pc, 64'h11);
    chk("wrap_stat", 64'(w_stat), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
